// File: rtl/ep_mdio_responder_if.sv
// ---------------------------------------------------------------------------
// ep_mdio_responder_if
// Request/response bundle between the endpoint MDIO_CR/MDIO_SR registers and
// the local PHY register responder.
//   req_stb_i   one-cycle request strobe (MDIO_CR write)
//   req_rw_i    1 = write, 0 = read
//   req_addr_i  register index
//   req_data_i  write data
//   rsp_ready_o MDIO_SR.READY
//   rsp_data_o  data of the last completed read
// Modports: master = endpoint side, slave = responder side.
// ---------------------------------------------------------------------------
interface ep_mdio_responder_if;
  logic        req_stb_i;
  logic        req_rw_i;
  logic [4:0]  req_addr_i;
  logic [15:0] req_data_i;
  logic        rsp_ready_o;
  logic [15:0] rsp_data_o;

  modport master (
    output req_stb_i, req_rw_i, req_addr_i, req_data_i,
    input  rsp_ready_o, rsp_data_o
  );

  modport slave (
    input  req_stb_i, req_rw_i, req_addr_i, req_data_i,
    output rsp_ready_o, rsp_data_o
  );
endinterface

// File: rtl/ep_mdio_responder.sv
// ---------------------------------------------------------------------------
// ep_mdio_responder
// Local PHY-style register file answering MDIO accesses issued by the
// endpoint: MCR (0), MSR (1), ADVERTISE (4), LPA (5).
//
// Parameters
//   g_reset_cycles  cycles pcs_reset_o is held after an MCR soft reset (2..255)
//   g_adv_default   reset value of ADVERTISE
// Ports
//   clk_sys_i       system clock (rising edge)
//   rst_n_i         asynchronous active-low reset
//   mdio            request/response bundle (slave modport)
//   link_up_i       PCS link status (feeds latched-low MSR bit 2)
//   an_complete_i   auto-negotiation complete (MSR bit 5, live)
//   lpa_i           link partner ability word
//   pcs_reset_o     high during a soft reset hold
//   loopback_o, powerdown_o, an_enable_o  mirror MCR bits 14, 11, 12
//   an_restart_o    one-cycle pulse on a write of MCR bit 9 = 1
// Configuration
//   EP_MDIO_RESP_LPA_EN  when defined, address 5 returns lpa_i; otherwise 0.
// ---------------------------------------------------------------------------
module ep_mdio_responder #(
  parameter int unsigned g_reset_cycles = 16,
  parameter logic [15:0] g_adv_default  = 16'h01A0
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  ep_mdio_responder_if.slave mdio,
  input  logic               link_up_i,
  input  logic               an_complete_i,
  input  logic [15:0]        lpa_i,
  output logic               pcs_reset_o,
  output logic               loopback_o,
  output logic               powerdown_o,
  output logic               an_enable_o,
  output logic               an_restart_o
);

  localparam logic [4:0]  ADDR_MCR = 5'd0;
  localparam logic [4:0]  ADDR_MSR = 5'd1;
  localparam logic [4:0]  ADDR_ADV = 5'd4;
  localparam logic [4:0]  ADDR_LPA = 5'd5;
  // Bits 15 (soft reset) and 9 (AN restart) never stay set in MCR.
  localparam logic [15:0] MCR_KEEP_MASK = 16'h7DFF;
  // Counter counts down to zero inclusive, so load one less than the hold.
  localparam logic [7:0]  HOLD_LOAD = 8'(g_reset_cycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_RST_HOLD
  } state_t;

  state_t      state_reg, state_next;
  logic        rw_reg, rw_next;
  logic [4:0]  addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic [15:0] mcr_reg, mcr_next;
  logic [15:0] adv_reg, adv_next;
  logic        link_latch_reg, link_latch_next;
  logic [15:0] rsp_data_reg, rsp_data_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;

  logic [15:0] msr_val;
  logic [15:0] lpa_rd;

`ifdef EP_MDIO_RESP_LPA_EN
  assign lpa_rd = lpa_i;
`else
  logic unused_lpa;
  assign unused_lpa = ^lpa_i;
  assign lpa_rd     = 16'h0000;
`endif

  // Extended status (8), AN complete (5), AN ability (3), latched link (2).
  assign msr_val = {7'b0, 1'b1, 2'b0, an_complete_i, 1'b0, 1'b1,
                    link_latch_reg, 2'b0};

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      rw_reg         <= 1'b0;
      addr_reg       <= 5'd0;
      data_reg       <= 16'h0000;
      mcr_reg        <= 16'h0000;
      adv_reg        <= g_adv_default;
      link_latch_reg <= 1'b0;
      rsp_data_reg   <= 16'h0000;
      hold_cnt_reg   <= 8'd0;
    end else begin
      state_reg      <= state_next;
      rw_reg         <= rw_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      mcr_reg        <= mcr_next;
      adv_reg        <= adv_next;
      link_latch_reg <= link_latch_next;
      rsp_data_reg   <= rsp_data_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rw_next         = rw_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    mcr_next        = mcr_reg;
    adv_next        = adv_reg;
    rsp_data_next   = rsp_data_reg;
    hold_cnt_next   = hold_cnt_reg;
    // Latched-low: any cycle with the link down clears the bit; only an MSR
    // read (below) may set it again.
    link_latch_next = link_latch_reg & link_up_i;

    case (state_reg)
      ST_IDLE: begin
        // The strobe lasts one cycle, so hold the request for ACCESS.
        if (mdio.req_stb_i) begin
          rw_next    = mdio.req_rw_i;
          addr_next  = mdio.req_addr_i;
          data_next  = mdio.req_data_i;
          state_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        state_next = ST_RESP;
        if (rw_reg) begin
          case (addr_reg)
            ADDR_MCR: begin
              mcr_next = data_reg & MCR_KEEP_MASK;
              if (data_reg[15]) begin
                state_next    = ST_RST_HOLD;
                hold_cnt_next = HOLD_LOAD;
              end
            end
            ADDR_ADV: adv_next = data_reg;
            default:  ;
          endcase
        end else begin
          case (addr_reg)
            ADDR_MCR: rsp_data_next = mcr_reg;
            ADDR_MSR: begin
              // Return the pre-update latch, then rearm from the live link;
              // a drop in this very cycle therefore stays latched.
              rsp_data_next   = msr_val;
              link_latch_next = link_up_i;
            end
            ADDR_ADV: rsp_data_next = adv_reg;
            ADDR_LPA: rsp_data_next = lpa_rd;
            default:  rsp_data_next = 16'h0000;
          endcase
        end
      end

      ST_RESP: state_next = ST_IDLE;

      ST_RST_HOLD: begin
        if (hold_cnt_reg == 8'd0) begin
          state_next = ST_IDLE;
          mcr_next   = 16'h0000;
          adv_next   = g_adv_default;
        end else begin
          hold_cnt_next = hold_cnt_reg - 8'd1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign mdio.rsp_ready_o = (state_reg == ST_IDLE);
  assign mdio.rsp_data_o  = rsp_data_reg;

  assign pcs_reset_o  = (state_reg == ST_RST_HOLD);
  assign loopback_o   = mcr_reg[14];
  assign powerdown_o  = mcr_reg[11];
  assign an_enable_o  = mcr_reg[12];
  assign an_restart_o = (state_reg == ST_ACCESS) && rw_reg &&
                        (addr_reg == ADDR_MCR) && data_reg[9];

endmodule

// File: tb/tb_ep_mdio_responder.sv
// ---------------------------------------------------------------------------
// tb_ep_mdio_responder
// Directed and randomized accesses against a register-level model of the
// responder (register values, latched link bit, handshake latency).
// ---------------------------------------------------------------------------
module tb_ep_mdio_responder;
  localparam int          RESET_CYC = 16;
  localparam logic [15:0] ADV_DEF   = 16'h01A0;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        an_complete;
  logic [15:0] lpa;
  logic        pcs_reset, loopback, powerdown, an_enable, an_restart;

  ep_mdio_responder_if bus ();

  ep_mdio_responder #(
    .g_reset_cycles (RESET_CYC),
    .g_adv_default  (ADV_DEF)
  ) dut (
    .clk_sys_i     (clk_sys),
    .rst_n_i       (rst_n),
    .mdio          (bus),
    .link_up_i     (link_up),
    .an_complete_i (an_complete),
    .lpa_i         (lpa),
    .pcs_reset_o   (pcs_reset),
    .loopback_o    (loopback),
    .powerdown_o   (powerdown),
    .an_enable_o   (an_enable),
    .an_restart_o  (an_restart)
  );

  always #5 clk_sys = ~clk_sys;

  // Free-running pulse counters, sampled mid-cycle.
  int unsigned pcs_total = 0;
  int unsigned ar_total  = 0;
  always @(negedge clk_sys) begin
    if (pcs_reset === 1'b1)  pcs_total <= pcs_total + 1;
    if (an_restart === 1'b1) ar_total  <= ar_total + 1;
  end

  int tests  = 0;
  int failed = 0;

  // Reference model state
  logic [15:0] mcr_m, adv_m, last_rd_m;
  logic        latch_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcr_m     = 16'h0000;
    adv_m     = ADV_DEF;
    latch_m   = 1'b0;
    last_rd_m = 16'h0000;
  endtask

  // One full access: model update, bus handshake, and checks.
  // drop = pull link_up low during the ACCESS cycle only.
  task automatic op(input string tag, input logic rw, input logic [4:0] a,
                    input logic [15:0] d, input bit drop, output logic [15:0] rd);
    int          lat, exp_lat;
    int unsigned pcs0, ar0, exp_pcs, exp_ar;
    logic [15:0] exp_rd;
    pcs0    = pcs_total;
    ar0     = ar_total;
    exp_lat = 3;
    exp_pcs = 0;
    exp_ar  = (rw && a == 5'd0 && d[9]) ? 1 : 0;
    exp_rd  = last_rd_m;
    if (rw) begin
      if (a == 5'd0) begin
        if (d[15]) begin
          mcr_m   = 16'h0000;
          adv_m   = ADV_DEF;
          exp_lat = RESET_CYC + 2;
          exp_pcs = RESET_CYC;
        end else begin
          mcr_m = d;
          mcr_m[9] = 1'b0;
        end
      end else if (a == 5'd4) begin
        adv_m = d;
      end
    end else begin
      case (a)
        5'd0: exp_rd = mcr_m;
        5'd1: begin
          exp_rd  = 16'h0108 | (16'(an_complete) << 5) | (16'(latch_m) << 2);
          latch_m = drop ? 1'b0 : link_up;
        end
        5'd4: exp_rd = adv_m;
`ifdef EP_MDIO_RESP_LPA_EN
        5'd5: exp_rd = lpa;
`endif
        default: exp_rd = 16'h0000;
      endcase
      last_rd_m = exp_rd;
    end

    @(negedge clk_sys);
    bus.req_stb_i  = 1'b1;
    bus.req_rw_i   = rw;
    bus.req_addr_i = a;
    bus.req_data_i = d;
    @(posedge clk_sys);
    #1;
    bus.req_stb_i  = 1'b0;
    bus.req_data_i = 16'($urandom);
    bus.req_addr_i = 5'($urandom);
    if (drop) link_up = 1'b0;
    lat = 1;
    while (bus.rsp_ready_o !== 1'b1 && lat < 300) begin
      @(posedge clk_sys);
      #1;
      if (drop) link_up = 1'b1;
      lat++;
    end
    if (drop) link_up = 1'b1;
    rd = bus.rsp_data_o;
    $display("[TB] %s rw=%0d addr=%0d data=%h rd=%h lat=%0d", tag, rw, a, d, rd, lat);
    chk({tag, ":lat"}, lat, exp_lat);
    chk({tag, ":rd"}, rd, exp_rd);
    chk({tag, ":pcs"}, pcs_total - pcs0, exp_pcs);
    chk({tag, ":restart"}, ar_total - ar0, exp_ar);
    chk({tag, ":mirror"}, {loopback, powerdown, an_enable}, {mcr_m[14], mcr_m[11], mcr_m[12]});
  endtask

  // Hold link down across at least one rising edge.
  task automatic link_pulse(input int cycles);
    @(negedge clk_sys);
    link_up = 1'b0;
    repeat (cycles) @(negedge clk_sys);
    link_up = 1'b1;
    latch_m = 1'b0;
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    logic [15:0] rd;
    logic [4:0]  ra;
    logic [15:0] rdat;
    logic        rrw;

    rst_n          = 1'b0;
    link_up        = 1'b1;
    an_complete    = 1'b0;
    lpa            = 16'h41A0;
    bus.req_stb_i  = 1'b0;
    bus.req_rw_i   = 1'b0;
    bus.req_addr_i = 5'd0;
    bus.req_data_i = 16'h0000;
    model_reset();

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst:ready", bus.rsp_ready_o, 1'b1);
    chk("rst:rdata", bus.rsp_data_o, 16'h0000);
    chk("rst:outs", {pcs_reset, an_restart, loopback, powerdown, an_enable}, 5'b0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;

    // Default ADVERTISE and basic latency
    op("adv_default", 1'b0, 5'd4, 16'h0, 1'b0, rd);
    chk("adv_default:const", rd, 16'h01A0);

    // Loopback via MCR, then AN restart self-clear
    op("mcr_wr_lb", 1'b1, 5'd0, 16'h4000, 1'b0, rd);
    op("mcr_rd_lb", 1'b0, 5'd0, 16'h0, 1'b0, rd);
    chk("mcr_rd_lb:const", {rd, loopback}, {16'h4000, 1'b1});
    op("mcr_wr_anr", 1'b1, 5'd0, 16'h0200, 1'b0, rd);
    op("mcr_rd_anr", 1'b0, 5'd0, 16'h0, 1'b0, rd);
    chk("mcr_rd_anr:const", rd, 16'h0000);

    // Soft reset restores MCR and ADVERTISE
    op("mcr_wr_mirror", 1'b1, 5'd0, 16'h5800, 1'b0, rd);
    op("adv_wr", 1'b1, 5'd4, 16'h0DE1, 1'b0, rd);
    op("adv_rd", 1'b0, 5'd4, 16'h0, 1'b0, rd);
    op("soft_reset", 1'b1, 5'd0, 16'h8000, 1'b0, rd);
    op("adv_after_sr", 1'b0, 5'd4, 16'h0, 1'b0, rd);
    chk("adv_after_sr:const", rd, 16'h01A0);
    op("mcr_after_sr", 1'b0, 5'd0, 16'h0, 1'b0, rd);
    chk("mcr_after_sr:const", rd, 16'h0000);

    // Latched-low link status
    an_complete = 1'b1;
    op("msr_prime", 1'b0, 5'd1, 16'h0, 1'b0, rd);
    op("msr_up", 1'b0, 5'd1, 16'h0, 1'b0, rd);
    chk("msr_up:const", rd, 16'h012C);
    link_pulse(1);
    op("msr_latched", 1'b0, 5'd1, 16'h0, 1'b0, rd);
    chk("msr_latched:bit2", rd[2], 1'b0);
    op("msr_rearmed", 1'b0, 5'd1, 16'h0, 1'b0, rd);
    chk("msr_rearmed:bit2", rd[2], 1'b1);
    op("msr_drop_same", 1'b0, 5'd1, 16'h0, 1'b1, rd);
    chk("msr_drop_same:bit2", rd[2], 1'b1);
    op("msr_after_drop", 1'b0, 5'd1, 16'h0, 1'b0, rd);
    chk("msr_after_drop:bit2", rd[2], 1'b0);

    // Strobe while busy is ignored
    @(negedge clk_sys);
    bus.req_stb_i  = 1'b1;
    bus.req_rw_i   = 1'b0;
    bus.req_addr_i = 5'd4;
    @(posedge clk_sys);
    #1;
    bus.req_rw_i   = 1'b1;
    bus.req_data_i = 16'h1234;
    @(posedge clk_sys);
    #1;
    bus.req_stb_i = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    last_rd_m = adv_m;
    chk("busy_strobe:ready", bus.rsp_ready_o, 1'b1);
    op("busy_strobe_adv", 1'b0, 5'd4, 16'h0, 1'b0, rd);
    chk("busy_strobe_adv:const", rd, 16'h01A0);

    // Link partner ability
    op("lpa_rd", 1'b0, 5'd5, 16'h0, 1'b0, rd);
`ifdef EP_MDIO_RESP_LPA_EN
    chk("lpa_rd:const", rd, 16'h41A0);
`else
    chk("lpa_rd:const", rd, 16'h0000);
`endif
    op("ro_write_msr", 1'b1, 5'd1, 16'hFFFF, 1'b0, rd);
    op("ro_write_lpa", 1'b1, 5'd5, 16'hFFFF, 1'b0, rd);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      an_complete = 1'($urandom);
      lpa         = 16'($urandom);
      if ($urandom_range(0, 3) == 0) link_pulse($urandom_range(1, 3));
      case ($urandom_range(0, 4))
        0:       ra = 5'd0;
        1:       ra = 5'd1;
        2:       ra = 5'd4;
        3:       ra = 5'd5;
        default: ra = 5'($urandom);
      endcase
      rrw  = 1'($urandom);
      rdat = 16'($urandom);
      if ($urandom_range(0, 7) != 0) rdat[15] = 1'b0;
      op($sformatf("rand%0d", i), rrw, ra, rdat, ($urandom_range(0, 7) == 0), rd);
    end

    // Reset in the middle of an access aborts it
    op("pre_abort_adv", 1'b1, 5'd4, 16'h3C3C, 1'b0, rd);
    @(negedge clk_sys);
    bus.req_stb_i  = 1'b1;
    bus.req_rw_i   = 1'b1;
    bus.req_addr_i = 5'd4;
    bus.req_data_i = 16'h5555;
    @(posedge clk_sys);
    #1;
    bus.req_stb_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort:ready", bus.rsp_ready_o, 1'b1);
    chk("abort:rdata", bus.rsp_data_o, 16'h0000);
    chk("abort:pcs", pcs_reset, 1'b0);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    op("abort_adv", 1'b0, 5'd4, 16'h0, 1'b0, rd);
    chk("abort_adv:const", rd, 16'h01A0);

    // Reset during the soft-reset hold
    op("sr_again", 1'b1, 5'd0, 16'h9000, 1'b0, rd);
    op("sr_mid_setup", 1'b1, 5'd4, 16'h0F0F, 1'b0, rd);
    @(negedge clk_sys);
    bus.req_stb_i  = 1'b1;
    bus.req_rw_i   = 1'b1;
    bus.req_addr_i = 5'd0;
    bus.req_data_i = 16'h8000;
    @(posedge clk_sys);
    #1;
    bus.req_stb_i = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("hold:pcs_high", pcs_reset, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("hold_abort:pcs", pcs_reset, 1'b0);
    chk("hold_abort:ready", bus.rsp_ready_o, 1'b1);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    op("hold_abort_msr", 1'b0, 5'd1, 16'h0, 1'b0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ep_mdio_responder.md
EP_MDIO_RESPONDER -- requirements
Module: ep_mdio_responder

Interface
REQ-001 Parameter g_reset_cycles, default 16: cycles pcs_reset_o is held after an MCR soft reset (range 2..255).
REQ-002 Parameter g_adv_default, default 16'h01A0: reset value of the ADVERTISE register.
REQ-003 clk_sys_i  in  1  system clock; single clock domain; all logic on its rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 req_stb_i  in  1  one-cycle request strobe from the endpoint MDIO_CR write.
REQ-006 req_rw_i  in  1  access type: 1 = write, 0 = read.
REQ-007 req_addr_i  in  5  register index (CR address field >> 2).
REQ-008 req_data_i  in  16  write data.
REQ-009 rsp_ready_o  out  1  MDIO_SR.READY: high when idle and the last access is complete.
REQ-010 rsp_data_o  out  16  read data of the last completed read.
REQ-011 link_up_i  in  1  PCS synchronisation / link status.
REQ-012 an_complete_i  in  1  auto-negotiation complete.
REQ-013 lpa_i  in  16  link partner ability word.
REQ-014 pcs_reset_o  out  1  PCS reset, high during a soft reset.
REQ-015 loopback_o, powerdown_o, an_enable_o  out  1 each  mirror MCR bits 14, 11 and 12.
REQ-016 an_restart_o  out  1  one-cycle pulse on a write of MCR bit 9 = 1.

Function
REQ-017 Register map: 0 MCR (r/w); 1 MSR (ro); 4 ADVERTISE (r/w); 5 LPA (ro). All other addresses read 16'h0000 and ignore writes.
REQ-018 FSM states: IDLE, ACCESS, RESP, RST_HOLD.
- IDLE + req_stb_i -> ACCESS.
- ACCESS -> RESP, or -> RST_HOLD on a write to MCR with bit 15 = 1.
- RESP -> IDLE.
- RST_HOLD -> IDLE when the hold counter expires.
REQ-019 rsp_ready_o is high only in IDLE; it goes low in the cycle after the accepted strobe and returns high 3 cycles after the strobe for a normal access.
REQ-020 Write commit and read capture into rsp_data_o happen in ACCESS; rsp_data_o holds its value until the next completed read, and writes do not change it.
REQ-021 req_stb_i asserted outside IDLE is ignored; no queueing.
REQ-022 MCR bit 15 is self-clearing: writing 1 drives pcs_reset_o high for exactly g_reset_cycles cycles. At expiry, MCR returns to 16'h0000 (bit 12 = 0) and ADVERTISE returns to g_adv_default, and rsp_ready_o rises in the following cycle.
REQ-023 MCR bit 9 is self-clearing: it always reads 0, and the write produces a single an_restart_o pulse in the ACCESS cycle.
REQ-024 MSR bit 2 (link status) is latched-low.
- Cleared the first cycle link_up_i is 0.
- Held at 0 until an MSR read, which returns the latched value.
- After that read the bit is reloaded from link_up_i in the same cycle.
REQ-025 A link drop in the same cycle as the MSR read returns the pre-drop value; the drop stays latched for the next read.
REQ-026 Remaining MSR bits: bit 5 = an_complete_i (live), bit 3 = 1 (AN ability), bit 8 = 1 (extended status); all others 0.
REQ-027 Writes to read-only registers complete with normal handshake timing and have no effect.

Reset
REQ-028 During and after rst_n_i low:
- State IDLE, rsp_ready_o = 1, rsp_data_o = 0.
- MCR = 0, ADVERTISE = g_adv_default, latched link bit = 0.
- pcs_reset_o = 0, an_restart_o = 0, mirrored outputs = 0.
REQ-029 rst_n_i asserted mid-access or in RST_HOLD aborts immediately to the reset state; the pending access has no effect.

Configuration
REQ-030 Macro EP_MDIO_RESP_LPA_EN:
- Defined: address 5 returns lpa_i, sampled in the ACCESS cycle.
- Undefined: address 5 reads 16'h0000; lpa_i stays a port but is unused.

Verification
REQ-031 After reset, read address 4 -> rsp_ready_o low for 2 cycles, then rsp_data_o = 16'h01A0.
REQ-032 Write MCR = 16'h4000, then read MCR -> 16'h4000 and loopback_o = 1; write MCR = 16'h0200 -> one an_restart_o pulse, MCR reads 16'h0000.
REQ-033 Write MCR = 16'h8000 with g_reset_cycles = 16 -> pcs_reset_o high for 16 cycles; afterwards ADVERTISE reads 16'h01A0 and MCR reads 16'h0000.
REQ-034 link_up_i = 1; read MSR (bit 2 = 1); pulse link_up_i low for 1 cycle; read MSR -> bit 2 = 0; read again -> bit 2 = 1.
REQ-035 Strobe a write of 16'h1234 to address 4 while rsp_ready_o = 0 -> ignored, ADVERTISE unchanged. With lpa_i = 16'h41A0, read address 5 -> 16'h41A0 when the macro is defined, 16'h0000 when it is not.
